// File: rtl/dmem_pkg.sv
// Shared types, widths and address checking for the data-memory responder.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADR_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Returns 1 when the byte address is not word aligned, or it falls
    // below the window base, or it lies beyond the last stored word.
    function automatic logic addr_err(
        input logic [ADR_W-1:0] adr,
        input logic [ADR_W-1:0] base,
        input int unsigned      depth_words
    );
        logic [ADR_W-1:0] off;
        off = adr - base;
        return (adr[1:0] != 2'b00) || (adr < base) ||
               ((off >> 2) >= ADR_W'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM backing the data-memory responder.
// Latency: rdata is registered, valid one edge after index is presented.
// Backpressure: none; a read and/or write is performed every edge.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Write-first port: a read of the word being written sees the new data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
            rdata      <= wdata;
        end else begin
            rdata      <= mem[index];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the MEM stage with programmable wait states.
// Latency: request accepted at edge N gives resp_valid after edge N+1+WAIT_STATES.
// Backpressure: response held stable until resp_ready; no new request accepted meanwhile.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned      DEPTH_WORDS = 256,
    parameter int unsigned      WAIT_STATES = 2,
    parameter logic [ADR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADR_W-1:0]  req_adr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 5;
    // WAIT spans the wait states plus the RAM read cycle, so the counter
    // starts one above WAIT_STATES and RESP is entered when it reaches 1.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES + 1);

    function automatic logic [IDX_W-1:0] word_index(input logic [ADR_W-1:0] adr);
        return IDX_W'((adr - BASE_ADDR) >> 2);
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              enter_resp;
    logic [CNT_W-1:0]  cnt;

    logic              wr_q;
    logic              err_q;
    logic [ADR_W-1:0]  adr_q;
    logic [WORD_W-1:0] wdata_q;

    logic              ram_we;
    logic [IDX_W-1:0]  ram_index;
    logic [WORD_W-1:0] ram_rdata;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // In IDLE the RAM is addressed straight from the request so the read
    // completes on the accept edge; afterwards the captured address is used.
    assign ram_index = (state == IDLE) ? word_index(req_adr) : word_index(adr_q);
    // Stores commit on the RESP entry edge only if the address was legal;
    // a reset on that same edge wins and the store is dropped.
    assign ram_we    = enter_resp && wr_q && !err_q && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake strobes.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 5'd1) begin
                    enter_resp = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, wait counter and registered response fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            adr_q      <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= CNT_LOAD;
                wr_q    <= req_wr;
                err_q   <= addr_err(req_adr, BASE_ADDR, DEPTH_WORDS);
                adr_q   <= req_adr;
                wdata_q <= req_wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - 5'd1;
            end
            if (enter_resp) begin
                resp_err   <= err_q;
                resp_rdata <= (wr_q || err_q) ? '0 : ram_rdata;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .index (ram_index),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_wr     [2];
    logic [31:0] req_adr    [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    // Instance 0: two wait states.
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut_w2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_adr(req_adr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    // Instance 1: zero wait states.
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_adr(req_adr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int u, input string tag);
        check({tag, "_req_ready"},  32'(req_ready[u]),  32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid[u]), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata[u],      32'd0);
        check({tag, "_resp_err"},   32'(resp_err[u]),   32'd0);
    endtask

    // One full transaction; called and returns at #1 after a rising edge.
    task automatic xact(input int u, input logic wr, input logic [31:0] adr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        logic [31:0] held;
        e.rd  = exp_rd;
        e.err = exp_err;
        e.lat = ((u == 0) ? 2 : 0) + 1;
        sb.push_back(e);
        check("req_ready_before_accept", 32'(req_ready[u]), 32'd1);
        req_valid[u] = 1'b1;
        req_wr[u]    = wr;
        req_adr[u]   = adr;
        req_wdata[u] = wd;
        @(posedge clk); #1;
        // Scramble the request bus: captured registers must be used.
        req_valid[u] = 1'b0;
        req_wr[u]    = 1'($urandom);
        req_adr[u]   = $urandom;
        req_wdata[u] = $urandom;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!resp_valid[u] && lat < 40);
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check("resp_latency", 32'(lat), 32'(got.lat));
            check("resp_rdata",   resp_rdata[u], got.rd);
            check("resp_err",     32'(resp_err[u]), 32'(got.err));
            check("req_ready_in_resp", 32'(req_ready[u]), 32'd0);
        end
        if (hold > 0) begin
            held = resp_rdata[u];
            req_valid[u] = 1'b1;
            req_wr[u]    = 1'b1;
            req_adr[u]   = 32'h0000_0010;
            req_wdata[u] = 32'h1111_2222;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                check("hold_resp_valid", 32'(resp_valid[u]), 32'd1);
                check("hold_resp_rdata", resp_rdata[u], held);
                check("hold_req_ready",  32'(req_ready[u]), 32'd0);
            end
            req_valid[u] = 1'b0;
        end
        resp_ready[u] = 1'b1;
        @(posedge clk); #1;
        resp_ready[u] = 1'b0;
        check("after_hs_resp_valid", 32'(resp_valid[u]), 32'd0);
        check("after_hs_req_ready",  32'(req_ready[u]),  32'd1);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            req_valid[u]  = 1'b0;
            req_wr[u]     = 1'b0;
            req_adr[u]    = '0;
            req_wdata[u]  = '0;
            resp_ready[u] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle(0, "reset_w2");
        check_idle(1, "reset_w0");
        rst = 1'b0;
        @(posedge clk); #1;

        // Two wait states: store then load back.
        xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        xact(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        // Misaligned store is rejected and leaves memory untouched.
        xact(0, 1'b1, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
        xact(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        // Range limits: one past the end errors, last word is legal.
        xact(0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 0);
        xact(0, 1'b1, 32'h3FC, 32'h5A5A_1234, 32'h0, 1'b0, 0);
        xact(0, 1'b0, 32'h3FC, 32'h0, 32'h5A5A_1234, 1'b0, 0);
        // Response backpressure with an ignored request pending.
        xact(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
        // The ignored store of 0x11112222 must not have landed.
        xact(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

        // Zero wait states on the second instance.
        xact(1, 1'b1, 32'h0, 32'h1234_5678, 32'h0, 1'b0, 0);
        xact(1, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0, 0);
        xact(1, 1'b0, 32'h401, 32'h0, 32'h0, 1'b1, 0);

        // Reset during the first WAIT cycle aborts a store.
        xact(0, 1'b1, 32'h20, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b1;
        req_adr[0]   = 32'h20;
        req_wdata[0] = 32'hAAAA_5555;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("accepted_before_rst", 32'(req_ready[0]), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle(0, "mid_wait_rst");
        @(posedge clk); #1;
        xact(0, 1'b0, 32'h20, 32'h0, 32'h0BAD_F00D, 1'b0, 0);
        // Memory of the other instance survives the shared reset.
        xact(1, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0, 0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
